// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   arb_state_e        : arbiter FSM state encoding (2 bits)
//   ArbStarveDefault   : default consecutive data grants allowed while fetch waits
//   ArbTimeoutDefault  : default cycles in a grant state before the access is aborted
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntIf = 2'd1,
    StGntDm = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned ArbStarveDefault  = 4;
  localparam int unsigned ArbTimeoutDefault = 16;

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Clear/enable counter with a terminal-count flag, used to bound how long the
// arbiter waits for a memory acknowledge.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear (wins over en)
//   en    : count enable; the count holds once terminal count is reached
//   tc    : high while the count equals MAX_COUNT-1
module mem_arbiter_timeout_ctr #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] Last = CW'(MAX_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single unified memory port between instruction fetch (read-only)
// and the memory stage (load/store). Data requests win over fetch unless fetch
// has already watched STARVE consecutive data grants. Accesses that are not
// acknowledged within TIMEOUT cycles are aborted and flagged in o_err.
//   i_clk, i_rst                : clock; asynchronous active-low reset
//   i_ce                        : enable, low only blocks new grants
//   i_if_req/addr, o_if_ack/rdata : fetch requester (level request, ack pulse)
//   i_dm_req/we/addr/wdata, o_dm_ack/rdata : data requester
//   o_mem_req/we/addr/wdata, i_mem_ack/rdata : memory handshake
//   o_stall_if                  : fetch waiting (request high, no ack this cycle)
//   o_err                       : sticky timeout flag, cleared only by reset
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH_MEM = 32,
  parameter int unsigned STARVE     = ArbStarveDefault,
  parameter int unsigned TIMEOUT    = ArbTimeoutDefault
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_if_req,
  input  logic [AWIDTH_MEM-1:0] i_if_addr,
  output logic                  o_if_ack,
  output logic [DWIDTH-1:0]     o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [AWIDTH_MEM-1:0] i_dm_addr,
  input  logic [DWIDTH-1:0]     i_dm_wdata,
  output logic                  o_dm_ack,
  output logic [DWIDTH-1:0]     o_dm_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [AWIDTH_MEM-1:0] o_mem_addr,
  output logic [DWIDTH-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DWIDTH-1:0]     i_mem_rdata,
  output logic                  o_stall_if,
  output logic                  o_err
);

  localparam int unsigned SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE);

  arb_state_e            state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [AWIDTH_MEM-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DWIDTH-1:0]     if_rdata_q, if_rdata_d;
  logic [DWIDTH-1:0]     dm_rdata_q, dm_rdata_d;
  logic                  err_q, err_d;
  logic                  in_gnt;
  logic                  tmo_tc;

  assign in_gnt = (state_q == StGntIf) || (state_q == StGntDm);

  // Counts cycles spent in a grant state; held at zero everywhere else.
  mem_arbiter_timeout_ctr #(
    .MAX_COUNT(TIMEOUT)
  ) u_timeout (
    .clk  (i_clk),
    .rst_n(i_rst),
    .clr  (!in_gnt),
    .en   (in_gnt),
    .tc   (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (i_ce) begin
          if (i_dm_req && !(i_if_req && (streak_q == StarveMax))) begin
            state_d     = StGntDm;
            owner_dm_d  = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = i_dm_we;
            mem_addr_d  = i_dm_addr;
            mem_wdata_d = i_dm_wdata;
            // Fetch cannot be waiting with the streak already at STARVE here,
            // so the increment never exceeds the saturation value.
            streak_d    = i_if_req ? streak_q + 1'b1 : '0;
          end else if (i_if_req) begin
            state_d     = StGntIf;
            owner_dm_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end

      StGntIf, StGntDm: begin
        if (i_mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (state_q == StGntDm) begin
            dm_rdata_d = i_mem_rdata;
          end else begin
            if_rdata_d = i_mem_rdata;
          end
        end else if (tmo_tc) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == StGntDm) begin
            dm_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      owner_dm_q  <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_if_ack    = (state_q == StResp) && !owner_dm_q;
  assign o_dm_ack    = (state_q == StResp) && owner_dm_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_err       = err_q;
  assign o_stall_if  = i_if_req && !o_if_ack;

endmodule
